fifo_stream_reader: RTL and testbench

Read-side adapter for the team's synchronous FIFO. Drives the FIFO read port (rd_en / registered dout / empty), absorbs the one-cycle read latency in a 2-entry output buffer, and presents the data as a valid/ready stream. Sustains one word per cycle when the FIFO is non-empty and the consumer is always ready. It sits between the FIFO and any downstream stream consumer, such as a serializer or packet engine.

---
 rtl/fifo_stream_reader.sv | 78 +++++++
 tb/tb_fifo_stream_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO: issues reads, absorbs the
// one-cycle read latency in a two-entry buffer and presents a valid/ready
// stream with a count of delivered words.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  words_out
);

  localparam int unsigned LVL_W = 3;

  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic [1:0]            occ_after_pop;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [DATA_WIDTH-1:0] tail_d;
  logic                  pop;
  logic [LVL_W-1:0]      level_after;

  assign m_data = head_q;

  // Next buffer state: pop shifts tail to head, in-flight word lands in the
  // first free slot left after the pop; a read is issued only if it fits.
  always_comb begin
    pop           = m_valid & m_ready;
    level_after   = LVL_W'(occ_q) + LVL_W'(inflight_q) - LVL_W'(pop);
    occ_after_pop = occ_q - 2'(pop);
    occ_d         = level_after[1:0];
    head_d        = head_q;
    tail_d        = tail_q;
    fifo_rd_en    = !rst && !fifo_empty && (level_after < LVL_W'(2));

    if (pop) begin
      head_d = tail_q;
    end
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        head_d = fifo_dout;
      end else begin
        tail_d = fifo_dout;
      end
    end
  end

  // State registers, registered valid flag and delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      m_valid    <= 1'b0;
      words_out  <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      head_q     <= head_d;
      tail_q     <= tail_d;
      m_valid    <= (occ_d != 2'd0);
      if (pop) begin
        words_out <= words_out + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized checks of fifo_stream_reader against a behavioral
// synchronous FIFO and an in-order scoreboard.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] words_out;

  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          fifo_flush = 1'b0;
  logic [DW-1:0] fq[$];

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .words_out  (words_out)
  );

  // Behavioral FIFO: registered dout, empty flag reflects contents after the edge.
  always @(posedge clk) begin
    if (fifo_flush) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (push_en) fq.push_back(push_data);
    end
    fifo_empty <= (fq.size() == 0);
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  int pops, rd_pulses, rd_empty_errs, order_errs, hold_errs, cyc, first_pop, last_pop;
  logic          s_rd, s_valid;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_words;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  typedef struct {
    logic          push;
    logic [DW-1:0] din;
    logic          rdy;
    logic          e_rd;
    logic          e_valid;
    logic          e_chk_data;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_words;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Sample outputs well before the edge, update the scoreboard, then advance.
  task automatic tick();
    logic [DW-1:0] e;
    #2;
    s_rd    = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_words = words_out;
    if (fifo_rd_en) rd_pulses++;
    if (fifo_rd_en && fifo_empty) rd_empty_errs++;
    if (prev_hold && (m_valid !== 1'b1 || m_data !== prev_data)) hold_errs++;
    if (push_en && !fifo_flush) exp_q.push_back(push_data);
    if (m_valid && m_ready && !rst) begin
      pops++;
      if (pops == 1) first_pop = cyc;
      last_pop = cyc;
      if (exp_q.size() == 0) begin
        order_errs++;
      end else begin
        e = exp_q.pop_front();
        if (e !== m_data) begin
          order_errs++;
          $display("[TB] order: got 0x%0h expected 0x%0h at cycle %0d", m_data, e, cyc);
        end
      end
    end
    prev_hold = m_valid && !m_ready && !rst;
    prev_data = m_data;
    if (fifo_flush) exp_q.delete();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    pops = 0; rd_pulses = 0; order_errs = 0; hold_errs = 0;
    first_pop = 0; last_pop = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; fifo_flush = 1'b1; m_ready = 1'b0; push_en = 1'b0;
    repeat (n) tick();
    rst = 1'b0; fifo_flush = 1'b0;
    clear_counts();
  endtask

  initial begin
    int pushed;
    rd_empty_errs = 0;
    cyc = 0;
    clear_counts();

    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 16'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};

    // Reset with a non-empty FIFO: no reads may be issued.
    rst = 1'b1; push_en = 1'b1; push_data = 8'h11;
    tick(); chk("rst_rd_c0", 32'(s_rd), 32'd0);
    push_en = 1'b0;
    tick(); chk("rst_rd_c1", 32'(s_rd), 32'd0);
    fifo_flush = 1'b1;
    tick(); chk("rst_rd_c2", 32'(s_rd), 32'd0);
    rst = 1'b0; fifo_flush = 1'b0;
    tick();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_data",  32'(s_data),  32'd0);
    chk("rst_words", 32'(s_words), 32'd0);
    clear_counts();

    // Single word, table driven.
    for (int i = 0; i < 6; i++) begin
      push_en = tbl[i].push; push_data = tbl[i].din; m_ready = tbl[i].rdy;
      tick();
      chk($sformatf("single_rd_%0d", i),    32'(s_rd),    32'(tbl[i].e_rd));
      chk($sformatf("single_valid_%0d", i), 32'(s_valid), 32'(tbl[i].e_valid));
      chk($sformatf("single_words_%0d", i), 32'(s_words), 32'(tbl[i].e_words));
      if (tbl[i].e_chk_data) chk($sformatf("single_data_%0d", i), 32'(s_data), 32'(tbl[i].e_data));
    end
    chk("single_order", 32'(order_errs), 32'd0);

    // Streaming 16 words with the consumer always ready once filled.
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      push_en = 1'b1; push_data = DW'(i);
      tick();
    end
    push_en = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 60 && pops < 16; k++) tick();
    chk("stream_pops",  32'(pops), 32'd16);
    chk("stream_order", 32'(order_errs), 32'd0);
    chk("stream_gap",   32'(last_pop - first_pop), 32'd15);
    chk("stream_words", 32'(words_out), 32'd16);
    chk("stream_hold",  32'(hold_errs), 32'd0);

    // Backpressure: 8 queued, consumer stalled.
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      push_en = 1'b1; push_data = DW'(i);
      tick();
    end
    push_en = 1'b0;
    repeat (10) tick();
    chk("bp_rd_pulses", 32'(rd_pulses), 32'd2);
    chk("bp_valid",     32'(s_valid), 32'd1);
    chk("bp_data",      32'(s_data), 32'd0);
    chk("bp_hold",      32'(hold_errs), 32'd0);
    m_ready = 1'b1;
    for (int k = 0; k < 40 && pops < 8; k++) tick();
    chk("bp_pops",  32'(pops), 32'd8);
    chk("bp_order", 32'(order_errs), 32'd0);
    chk("bp_words", 32'(words_out), 32'd8);

    // Random consumer readiness and bursty FIFO fill.
    do_reset(2);
    pushed = 0;
    for (int k = 0; k < 8000 && pops < 1000; k++) begin
      push_en   = (pushed < 1000) && ($urandom_range(0, 9) < 6);
      push_data = DW'($urandom);
      m_ready   = $urandom_range(0, 1) == 1;
      if (push_en) pushed++;
      tick();
    end
    chk("rand_pops",   32'(pops), 32'd1000);
    chk("rand_order",  32'(order_errs), 32'd0);
    chk("rand_hold",   32'(hold_errs), 32'd0);
    chk("rand_left",   32'(exp_q.size()), 32'd0);
    chk("rand_words",  32'(words_out), 32'd1000);

    // Reset in mid-stream with a full buffer.
    do_reset(2);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_en = 1'b1; push_data = DW'(8'h50 + i);
      tick();
    end
    push_en = 1'b0; m_ready = 1'b0;
    repeat (6) tick();
    chk("mid_pre_valid", 32'(s_valid), 32'd1);
    chk("mid_pre_words", 32'(s_words), 32'd3);
    rst = 1'b1; fifo_flush = 1'b1;
    tick();
    rst = 1'b0; fifo_flush = 1'b0;
    chk("mid_valid", 32'(m_valid), 32'd0);
    chk("mid_words", 32'(words_out), 32'd0);
    clear_counts();
    m_ready = 1'b1; push_en = 1'b1; push_data = 8'h3C;
    tick();
    push_en = 1'b0;
    for (int k = 0; k < 10 && pops < 1; k++) tick();
    chk("mid_pops",  32'(pops), 32'd1);
    chk("mid_order", 32'(order_errs), 32'd0);
    chk("mid_words_after", 32'(words_out), 32'd1);

    chk("rd_while_empty", 32'(rd_empty_errs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
